key_mode_selector: RTL and testbench



---
 rtl/key_pkg.sv | 24 ++
 rtl/key_debounce_channel.sv | 76 +++++++
 rtl/key_mode_selector.sv | 130 +++++++++++++
 tb/tb_key_mode_selector.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// key_pkg
// Shared definitions for the push-button front end: default debounce length,
// default mode count, the key indices that drive mode stepping, and a helper
// that sizes counters from their largest value.
package key_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 8;
  localparam int DEFAULT_NUM_MODES       = 4;

  // Key indices that step the mode index; higher keys are debounce-only.
  localparam int KEY_NEXT = 0;
  localparam int KEY_PREV = 1;

  // Number of bits needed to hold every value in 0..max_value (at least 1).
  function automatic int cnt_width(input int max_value);
    int w;
    w = 1;
    while (((64'd1 << w) <= 64'(max_value)) && (w < 31)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel
// One push-button channel: a 2-flop synchroniser, a stability counter and the
// accepted level, plus one-cycle press/release pulses that coincide with the
// first cycle the new level is visible.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high
//   key_n        raw button, active-low, asynchronous to clk
//   key_level    debounced state, 1 = pressed
//   key_press    one-cycle pulse when a press is accepted
//   key_release  one-cycle pulse when a release is accepted
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          press_reg;
  logic          release_reg;

  logic sample_pressed;
  logic mismatch;

  assign sample_pressed = ~sync2_reg;
  assign mismatch       = sample_pressed ^ level_reg;

  // The counter holds the number of consecutive mismatching samples already
  // seen; the level flips on the DEBOUNCE_CYCLES-th one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      sync1_reg   <= key_n;
      sync2_reg   <= sync1_reg;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      if (mismatch) begin
        if (cnt_reg == CNT_LAST) begin
          cnt_reg     <= '0;
          level_reg   <= sample_pressed;
          press_reg   <= sample_pressed;
          release_reg <= ~sample_pressed;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign key_level   = level_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;

endmodule

// File: rtl/key_mode_selector.sv
// key_mode_selector
// Debounces NUM_KEYS active-low buttons and maintains a wrap-around mode index.
// Key 0 steps the mode forward, key 1 steps it back; with REPEAT_DELAY > 0 a
// held mode key auto-repeats after REPEAT_DELAY cycles and then every
// REPEAT_PERIOD cycles. Simultaneous forward and back steps cancel.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high
//   keys_n        raw buttons, active-low, asynchronous to clk
//   key_level     debounced state per key, 1 = pressed
//   key_press     one-cycle pulse per key on accepted press
//   key_release   one-cycle pulse per key on accepted release
//   mode          current mode index, 0..NUM_MODES-1
//   mode_changed  one-cycle pulse when mode changes
module key_mode_selector
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int NUM_MODES       = DEFAULT_NUM_MODES,
  parameter int MODE_W          = $clog2(NUM_MODES),
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [MODE_W-1:0]   mode,
  output logic                mode_changed
);

  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

  // ---------------------------------------------------------------------------
  // Per-key debounce channels
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
      key_debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
        .clk        (clk),
        .reset      (reset),
        .key_n      (keys_n[gi]),
        .key_level  (key_level[gi]),
        .key_press  (key_press[gi]),
        .key_release(key_release[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Auto-repeat for the two mode keys
  // ---------------------------------------------------------------------------
  // repeat_tick[0] belongs to KEY_NEXT, repeat_tick[1] to KEY_PREV.
  logic [1:0] repeat_tick;

  generate
    if (REPEAT_DELAY > 0) begin : g_repeat
      localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RCW = cnt_width(RPT_MAX);
      localparam logic [RCW-1:0] DELAY_C  = RCW'(REPEAT_DELAY);
      localparam logic [RCW-1:0] PERIOD_C = RCW'(REPEAT_PERIOD);

      for (gi = 0; gi < 2; gi++) begin : g_key
        // hold_cnt_reg is 0 in the key_press cycle and counts held cycles from
        // there; after the first tick it restarts at 1 and counts the period.
        logic [RCW-1:0] hold_cnt_reg;
        logic           repeating_reg;

        assign repeat_tick[gi] = key_level[gi] &
                                 (repeating_reg ? (hold_cnt_reg == PERIOD_C)
                                                : (hold_cnt_reg == DELAY_C));

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            hold_cnt_reg  <= '0;
            repeating_reg <= 1'b0;
          end else if (!key_level[gi]) begin
            hold_cnt_reg  <= '0;
            repeating_reg <= 1'b0;
          end else if (repeat_tick[gi]) begin
            hold_cnt_reg  <= RCW'(1);
            repeating_reg <= 1'b1;
          end else begin
            hold_cnt_reg  <= hold_cnt_reg + RCW'(1);
          end
        end
      end
    end else begin : g_no_repeat
      assign repeat_tick = 2'b00;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Mode register
  // ---------------------------------------------------------------------------
  logic step_next;
  logic step_prev;

  assign step_next = key_press[KEY_NEXT] | repeat_tick[0];
  assign step_prev = key_press[KEY_PREV] | repeat_tick[1];

  logic [MODE_W-1:0] mode_reg;
  logic              mode_changed_reg;

  // Opposite steps in the same cycle cancel: no move and no change pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg         <= '0;
      mode_changed_reg <= 1'b0;
    end else begin
      mode_changed_reg <= step_next ^ step_prev;
      if (step_next && !step_prev) begin
        mode_reg <= (mode_reg == MODE_MAX) ? '0 : mode_reg + MODE_W'(1);
      end else if (step_prev && !step_next) begin
        mode_reg <= (mode_reg == '0) ? MODE_MAX : mode_reg - MODE_W'(1);
      end
    end
  end

  assign mode         = mode_reg;
  assign mode_changed = mode_changed_reg;

endmodule

// File: tb/tb_key_mode_selector.sv
// tb_key_mode_selector
// Self-checking bench for key_mode_selector with NUM_KEYS=3, DEBOUNCE_CYCLES=4,
// NUM_MODES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5. A behavioural model tracks the
// expected outputs every cycle; directed phases add targeted checks.
module tb_key_mode_selector;

  localparam int NK = 3;
  localparam int DB = 4;
  localparam int NM = 4;
  localparam int MW = 2;
  localparam int RD = 20;
  localparam int RP = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] keys_n = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [MW-1:0] mode;
  logic          mode_changed;

  always #5 clk = ~clk;

  key_mode_selector #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .NUM_MODES      (NM),
    .MODE_W         (MW),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .keys_n      (keys_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .mode        (mode),
    .mode_changed(mode_changed)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: raw input seen two cycles late, a level accepted after DB
  // consecutive disagreeing samples, held-time arithmetic for auto-repeat and
  // modular arithmetic for the mode index.
  // ---------------------------------------------------------------------------
  bit [NK-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
  int          m_run [NK];
  int          m_held[2];
  int          m_mode;
  bit          m_chg;

  function automatic bit m_tick(input int k);
    return m_lvl[k] && (m_held[k] >= RD) && (((m_held[k] - RD) % RP) == 0);
  endfunction

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_lvl = '0; m_press = '0; m_rel = '0;
    for (int k = 0; k < NK; k++) m_run[k] = 0;
    m_held[0] = 0; m_held[1] = 0;
    m_mode = 0; m_chg = 1'b0;
  endtask

  task automatic model_update(input bit [NK-1:0] kn);
    bit nx, pv, sample;
    bit [NK-1:0] old_lvl;
    nx = m_press[0] | m_tick(0);
    pv = m_press[1] | m_tick(1);
    m_chg = nx ^ pv;
    if (nx && !pv) m_mode = (m_mode + 1) % NM;
    else if (pv && !nx) m_mode = (m_mode + NM - 1) % NM;
    old_lvl = m_lvl;
    for (int k = 0; k < NK; k++) begin
      sample = ~m_s2[k];
      m_press[k] = 1'b0;
      m_rel[k] = 1'b0;
      if (sample != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          m_lvl[k] = sample;
          m_run[k] = 0;
          m_press[k] = sample;
          m_rel[k] = !sample;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    for (int k = 0; k < 2; k++)
      m_held[k] = (m_lvl[k] && old_lvl[k]) ? m_held[k] + 1 : 0;
    m_s2 = m_s1;
    m_s1 = kn;
  endtask

  function automatic logic [31:0] obs_word();
    return {20'd0, key_level, key_press, key_release, mode, mode_changed};
  endfunction

  function automatic logic [31:0] exp_word();
    logic [MW-1:0] mm;
    mm = m_mode[MW-1:0];
    return {20'd0, m_lvl, m_press, m_rel, mm, m_chg};
  endfunction

  // ---------------------------------------------------------------------------
  // Cycle stepping and tallies
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int press_cnt[NK];
  int rel_cnt[NK];
  int last_press_cyc[NK];
  int chg_cnt, both_cnt, nonzero_cnt;
  int chg_q[$];
  int chg_mode_q[$];

  task automatic clear_tally();
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0; rel_cnt[k] = 0; last_press_cyc[k] = -1000;
    end
    chg_cnt = 0; both_cnt = 0; nonzero_cnt = 0;
    chg_q.delete();
    chg_mode_q.delete();
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after
  // the rising edge.
  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_update(keys_n);
    #1;
    cyc++;
    for (int k = 0; k < NK; k++) begin
      if (key_press[k] === 1'b1) begin press_cnt[k]++; last_press_cyc[k] = cyc; end
      if (key_release[k] === 1'b1) rel_cnt[k]++;
    end
    if (mode_changed === 1'b1) begin
      chg_cnt++;
      chg_q.push_back(cyc);
      chg_mode_q.push_back(int'(mode));
    end
    if (key_press[1:0] === 2'b11) both_cnt++;
    if (obs_word() !== 32'd0) nonzero_cnt++;
    check_eq("cycle", obs_word(), exp_word());
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic tap(input int k, input int hold, input int gap);
    keys_n[k] = 1'b0;
    idle(hold);
    keys_n[k] = 1'b1;
    idle(gap);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("reset_async", obs_word(), 32'd0);
    idle(2);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int c0;
  int exp_wrap[4] = '{1, 2, 3, 0};
  int exp_rpt_off[5] = '{1, 21, 26, 31, 36};
  int exp_rpt_mode[5] = '{1, 2, 3, 0, 1};
  int remain[NK];

  initial begin
    model_reset();
    clear_tally();
    @(negedge clk);
    idle(3);
    reset = 1'b0;

    // Idle after reset
    clear_tally();
    idle(100);
    check_eq("idle_quiet", nonzero_cnt, 0);

    // Short glitch rejected
    clear_tally();
    keys_n[0] = 1'b0; idle(3); keys_n[0] = 1'b1; idle(15);
    check_eq("glitch_press", press_cnt[0], 0);
    check_eq("glitch_mode", mode, 0);

    // Accepted press, latency, mode step, release
    clear_tally();
    c0 = cyc;
    keys_n[0] = 1'b0; idle(10); keys_n[0] = 1'b1; idle(15);
    check_eq("press_count", press_cnt[0], 1);
    check_eq("press_latency", last_press_cyc[0] - c0, 6);
    check_eq("press_mode", mode, 1);
    check_eq("press_chg_count", chg_cnt, 1);
    check_eq("press_chg_delay", (chg_q.size() > 0) ? chg_q[0] - last_press_cyc[0] : -1, 1);
    check_eq("release_count", rel_cnt[0], 1);

    // Wrap forward and backward, debounce-only key
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tap(0, 8, 12);
      check_eq($sformatf("wrap_next%0d", i), mode, exp_wrap[i]);
    end
    tap(1, 8, 12);
    check_eq("wrap_prev", mode, 3);
    clear_tally();
    tap(2, 8, 12);
    check_eq("key2_press", press_cnt[2], 1);
    check_eq("key2_mode", mode, 3);
    check_eq("key2_chg", chg_cnt, 0);

    // Simultaneous NEXT and PREV
    clear_tally();
    keys_n[1:0] = 2'b00; idle(10); keys_n[1:0] = 2'b11; idle(15);
    check_eq("both_press", both_cnt, 1);
    check_eq("both_mode", mode, 3);
    check_eq("both_chg", chg_cnt, 0);

    // Auto-repeat: raw held 40 cycles gives 40 cycles of key_level
    do_reset();
    clear_tally();
    keys_n[0] = 1'b0; idle(40); keys_n[0] = 1'b1; idle(30);
    check_eq("rpt_count", chg_cnt, 5);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("rpt_off%0d", i),
               (chg_q.size() > i) ? chg_q[i] - last_press_cyc[0] : -1, exp_rpt_off[i]);
      check_eq($sformatf("rpt_mode%0d", i),
               (chg_mode_q.size() > i) ? chg_mode_q[i] : -1, exp_rpt_mode[i]);
    end

    // Reset while NEXT is mid-debounce with mode=2, key held through reset
    tap(0, 8, 12);
    check_eq("pre_reset_mode", mode, 2);
    keys_n[0] = 1'b0;
    idle(2);
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("midrst_mode", mode, 0);
    check_eq("midrst_level", key_level, 0);
    idle(3);
    reset = 1'b0;
    clear_tally();
    c0 = cyc;
    idle(12);
    check_eq("held_press_count", press_cnt[0], 1);
    check_eq("held_press_latency", last_press_cyc[0] - c0, 6);
    check_eq("held_press_mode", mode, 1);
    keys_n[0] = 1'b1;
    idle(15);

    // Randomised key activity against the model
    for (int k = 0; k < NK; k++) remain[k] = $urandom_range(1, 30);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        for (int k = 0; k < NK; k++) begin
          remain[k]--;
          if (remain[k] <= 0) begin
            keys_n[k] = ~keys_n[k];
            remain[k] = $urandom_range(1, 45);
          end
        end
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
